// File: rtl/axis_profile_window_if.sv
// AXI-Stream sideband view used by the profiler: handshake, tlast, tkeep and tuser.
// Monitor modport is observe-only.
interface AXIS_int #(
    parameter int KEEP_WIDTH = 8,
    parameter int USER_WIDTH = 1
) (
    input logic clk,
    input logic sresetn
);
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic [USER_WIDTH-1:0] tuser;

    modport Monitor (input clk, sresetn, tvalid, tready, tlast, tkeep, tuser);
endinterface

// File: rtl/axis_profile_window.sv
// Windowed AXI-Stream profiler: live event counters copied atomically into snapshot
// registers at window end or on request, with no events dropped across the copy.
module axis_profile_window_cnt #(
    parameter int W        = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         snap,
    input  logic [W-1:0] inc,
    output logic [W-1:0] cnt,
    output logic         ovf
);
    logic [W-1:0] base;
    logic [W:0]   sum;

    // On a snapshot the counter restarts from this cycle's own contribution.
    assign base = snap ? '0 : cnt;
    assign sum  = {1'b0, base} + {1'b0, inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            cnt <= (sum[W] && SATURATE) ? '1 : sum[W-1:0];
            ovf <= (ovf & ~snap) | sum[W];
        end
    end
endmodule

module axis_profile_window #(
    parameter int                     COUNT_WIDTH             = 32,
    parameter int                     WINDOW_WIDTH            = 32,
    parameter int                     TUSER_WIDTH             = 1,
    parameter logic [TUSER_WIDTH-1:0] TUSER_BAD_FRAME_VALUE   = TUSER_WIDTH'(1),
    parameter logic [TUSER_WIDTH-1:0] TUSER_BAD_FRAME_MASK    = TUSER_WIDTH'(1),
    parameter bit                     ONLY_BAD_FRAME_ON_TLAST = 1'b1,
    parameter bit                     SATURATE                = 1'b1
) (
    AXIS_int.Monitor                           axis,
    input  logic                               enable,
    input  logic                               clear_stb,
    input  logic [WINDOW_WIDTH-1:0]            window_cycles,
    input  logic                               snapshot_stb,
    output logic                               snap_valid,
    output logic [15:0]                        snap_seq,
    output logic [8:0][COUNT_WIDTH-1:0]        snap_counts,
    output logic [8:0]                         snap_overflow
);
    if ($bits(axis.tuser) != TUSER_WIDTH) begin : g_tuser_width_check
        $error("axis_profile_window: TUSER_WIDTH does not match axis tuser width");
    end

    logic rst, bp, stall, active, idle, bad, win_hit, trig;
    logic [COUNT_WIDTH-1:0]      pop;
    logic [6:0][COUNT_WIDTH-1:0] inc, cnt_live;
    logic [6:0]                  cnt_ovf;
    logic [WINDOW_WIDTH-1:0]     win_cnt;

    assign rst    = ~axis.sresetn | clear_stb;
    assign bp     = axis.tvalid & ~axis.tready;
    assign stall  = ~axis.tvalid & axis.tready;
    assign active = axis.tvalid & axis.tready;
    assign idle   = ~axis.tvalid & ~axis.tready;
    assign bad    = ((axis.tuser & TUSER_BAD_FRAME_MASK) == TUSER_BAD_FRAME_VALUE) &&
                    (!ONLY_BAD_FRAME_ON_TLAST || axis.tlast);
    assign pop    = COUNT_WIDTH'($countones(axis.tkeep));

    assign win_hit = enable && (window_cycles != '0) &&
                     (win_cnt >= window_cycles - WINDOW_WIDTH'(1));
    assign trig    = win_hit | snapshot_stb;

    // Lanes: 0 bytes, 1 idle, 2 active, 3 stall, 4 bp, 5 frame, 6 error.
    always_comb begin
        inc = '0;
        if (enable) begin
            inc[0] = active ? pop : '0;
            inc[1] = COUNT_WIDTH'(idle);
            inc[2] = COUNT_WIDTH'(active);
            inc[3] = COUNT_WIDTH'(stall);
            inc[4] = COUNT_WIDTH'(bp);
            inc[5] = COUNT_WIDTH'(active & axis.tlast);
            inc[6] = COUNT_WIDTH'(active & bad);
        end
    end

    for (genvar i = 0; i < 7; i++) begin : g_cnt
        axis_profile_window_cnt #(.W(COUNT_WIDTH), .SATURATE(SATURATE)) u_cnt (
            .clk  (axis.clk),
            .rst  (rst),
            .snap (trig),
            .inc  (inc[i]),
            .cnt  (cnt_live[i]),
            .ovf  (cnt_ovf[i])
        );
    end

    logic [COUNT_WIDTH-1:0] cur_frame, cur_run, max_frame, max_run;
    logic [COUNT_WIDTH-1:0] frame_len, run_len, max_frame_base, max_run_base;
    logic [COUNT_WIDTH:0]   frame_sum, run_sum;
    logic                   ovf_frame, ovf_run, frame_done, run_step;

    // In-progress frame and bp run live outside the window so they span snapshots.
    always_comb begin
        frame_sum      = {1'b0, cur_frame} + {1'b0, pop};
        frame_len      = (frame_sum[COUNT_WIDTH] && SATURATE) ? '1 : frame_sum[COUNT_WIDTH-1:0];
        run_sum        = {1'b0, cur_run} + (COUNT_WIDTH + 1)'(1);
        run_len        = (run_sum[COUNT_WIDTH] && SATURATE) ? '1 : run_sum[COUNT_WIDTH-1:0];
        max_frame_base = trig ? '0 : max_frame;
        max_run_base   = trig ? '0 : max_run;
        frame_done     = enable & active & axis.tlast;
        run_step       = enable & bp;
    end

    always_ff @(posedge axis.clk) begin
        if (rst) begin
            cur_frame <= '0;
            cur_run   <= '0;
            max_frame <= '0;
            max_run   <= '0;
            ovf_frame <= 1'b0;
            ovf_run   <= 1'b0;
        end else begin
            if (enable && active) cur_frame <= axis.tlast ? '0 : frame_len;
            if (enable)           cur_run   <= bp ? run_len : '0;
            max_frame <= (frame_done && frame_len > max_frame_base) ? frame_len : max_frame_base;
            max_run   <= (run_step && run_len > max_run_base) ? run_len : max_run_base;
            ovf_frame <= (ovf_frame & ~trig) | (enable & active & frame_sum[COUNT_WIDTH]);
            ovf_run   <= (ovf_run & ~trig) | (run_step & run_sum[COUNT_WIDTH]);
        end
    end

    always_ff @(posedge axis.clk) begin
        if (rst) begin
            win_cnt       <= '0;
            snap_valid    <= 1'b0;
            snap_seq      <= '0;
            snap_counts   <= '0;
            snap_overflow <= '0;
        end else begin
            if (trig)
                win_cnt <= '0;
            else if (enable && window_cycles != '0)
                win_cnt <= win_cnt + WINDOW_WIDTH'(1);
            snap_valid <= trig;
            if (trig) begin
                snap_counts   <= {max_run, max_frame, cnt_live};
                snap_overflow <= {ovf_run, ovf_frame, cnt_ovf};
                snap_seq      <= snap_seq + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_axis_profile_window.sv
// Bench for axis_profile_window: history-based reference model for the default-parameter
// instance, plus directed checks on two narrow-counter / 2-bit-tuser instances.
module tb_axis_profile_window;
    localparam int MAXC = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, tvalid, tready, tlast, enable, clear_stb, snapshot_stb;
    logic [7:0]  tkeep;
    logic [1:0]  tuser;
    logic [31:0] window_cycles;

    AXIS_int #(.KEEP_WIDTH(8), .USER_WIDTH(1)) ax0 (.clk(clk), .sresetn(rst_n));
    AXIS_int #(.KEEP_WIDTH(8), .USER_WIDTH(2)) ax1 (.clk(clk), .sresetn(rst_n));
    AXIS_int #(.KEEP_WIDTH(8), .USER_WIDTH(2)) ax2 (.clk(clk), .sresetn(rst_n));
    assign ax0.tvalid = tvalid; assign ax0.tready = tready; assign ax0.tlast = tlast;
    assign ax0.tkeep  = tkeep;  assign ax0.tuser  = tuser[1];
    assign ax1.tvalid = tvalid; assign ax1.tready = tready; assign ax1.tlast = tlast;
    assign ax1.tkeep  = tkeep;  assign ax1.tuser  = tuser;
    assign ax2.tvalid = tvalid; assign ax2.tready = tready; assign ax2.tlast = tlast;
    assign ax2.tkeep  = tkeep;  assign ax2.tuser  = tuser;

    logic             snap_valid, sv1, sv2;
    logic [15:0]      snap_seq, sq1, sq2;
    logic [8:0][31:0] snap_counts;
    logic [8:0][3:0]  c1, c2;
    logic [8:0]       snap_overflow, o1, o2;

    axis_profile_window dut (
        .axis(ax0), .enable(enable), .clear_stb(clear_stb), .window_cycles(window_cycles),
        .snapshot_stb(snapshot_stb), .snap_valid(snap_valid), .snap_seq(snap_seq),
        .snap_counts(snap_counts), .snap_overflow(snap_overflow));

    axis_profile_window #(.COUNT_WIDTH(4), .TUSER_WIDTH(2), .TUSER_BAD_FRAME_VALUE(2'b10),
        .TUSER_BAD_FRAME_MASK(2'b10), .ONLY_BAD_FRAME_ON_TLAST(1'b0), .SATURATE(1'b1)) dut_sat (
        .axis(ax1), .enable(enable), .clear_stb(clear_stb), .window_cycles(32'd0),
        .snapshot_stb(snapshot_stb), .snap_valid(sv1), .snap_seq(sq1),
        .snap_counts(c1), .snap_overflow(o1));

    axis_profile_window #(.COUNT_WIDTH(4), .TUSER_WIDTH(2), .TUSER_BAD_FRAME_VALUE(2'b10),
        .TUSER_BAD_FRAME_MASK(2'b10), .ONLY_BAD_FRAME_ON_TLAST(1'b1), .SATURATE(1'b0)) dut_wrap (
        .axis(ax2), .enable(enable), .clear_stb(clear_stb), .window_cycles(32'd0),
        .snapshot_stb(snapshot_stb), .snap_valid(sv2), .snap_seq(sq2),
        .snap_counts(c2), .snap_overflow(o2));

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: full per-cycle history; each snapshot is recomputed from the
    // recorded cycles of its window, with frames and bp runs traced back through history.
    bit          h_en[MAXC], h_tv[MAXC], h_tr[MAXC], h_tl[MAXC], h_bad[MAXC];
    int          h_pop[MAXC];
    int          cyc = 0, hist_start = 0, win_start = 0, exp_seq = 0;
    longint      wcnt = 0;
    bit          exp_valid = 0, chk_all = 0;
    longint      exp_cnt[9];
    logic [8:0]  exp_ovf;
    longint      beat_acc = 0;

    task automatic calc_window(input int ws, input int we);
        longint s[9];
        longint lim = 64'hFFFF_FFFF;
        for (int i = 0; i < 9; i++) s[i] = 0;
        for (int c = ws; c <= we; c++) begin
            if (!h_en[c]) continue;
            if (h_tv[c] && !h_tr[c]) begin
                longint run = 0;
                s[4]++;
                for (int k = c; k >= hist_start; k--) begin
                    if (!h_en[k]) continue;
                    if (h_tv[k] && !h_tr[k]) run++; else break;
                end
                if (run > s[8]) s[8] = run;
            end
            if (!h_tv[c] && h_tr[c])  s[3]++;
            if (!h_tv[c] && !h_tr[c]) s[1]++;
            if (h_tv[c] && h_tr[c]) begin
                s[2]++;
                s[0] += h_pop[c];
                if (h_tl[c]) begin
                    longint len = 0;
                    s[5]++;
                    if (h_bad[c]) s[6]++;
                    for (int k = c; k >= hist_start; k--) begin
                        if (!(h_en[k] && h_tv[k] && h_tr[k])) continue;
                        if (k != c && h_tl[k]) break;
                        len += h_pop[k];
                    end
                    if (len > s[7]) s[7] = len;
                end
            end
        end
        for (int i = 0; i < 9; i++) begin
            exp_ovf[i] = (s[i] > lim);
            exp_cnt[i] = (s[i] > lim) ? lim : s[i];
        end
    endtask

    task automatic model_cycle();
        bit trig;
        h_en[cyc] = enable; h_tv[cyc] = tvalid; h_tr[cyc] = tready; h_tl[cyc] = tlast;
        h_bad[cyc] = tuser[1]; h_pop[cyc] = $countones(tkeep);
        chk_all = 0;
        if (!rst_n || clear_stb) begin
            hist_start = cyc + 1; win_start = cyc + 1; wcnt = 0; exp_seq = 0;
            exp_valid = 0; chk_all = 1; exp_ovf = '0;
            for (int i = 0; i < 9; i++) exp_cnt[i] = 0;
        end else begin
            trig = snapshot_stb ||
                   (enable && window_cycles != 0 && wcnt >= longint'(window_cycles) - 1);
            if (trig) wcnt = 0;
            else if (enable && window_cycles != 0) wcnt++;
            exp_valid = trig;
            if (trig) begin
                calc_window(win_start, cyc - 1);
                exp_seq = (exp_seq + 1) % 65536;
                win_start = cyc;
            end
        end
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        model_cycle();
        @(negedge clk);
        chk($sformatf("snap_valid@%0d", cyc), snap_valid, exp_valid);
        chk($sformatf("snap_seq@%0d", cyc), snap_seq, exp_seq);
        if (exp_valid || chk_all) begin
            for (int i = 0; i < 9; i++)
                chk($sformatf("snap_counts[%0d]@%0d", i, cyc), snap_counts[i], exp_cnt[i]);
            chk($sformatf("snap_overflow@%0d", cyc), snap_overflow, exp_ovf);
        end
        if (snap_valid) beat_acc += snap_counts[2];
    endtask

    task automatic drive(input bit v, input bit r, input bit l, input logic [7:0] k);
        tvalid = v; tready = r; tlast = l; tkeep = k;
    endtask

    initial begin
        int wsel[6] = '{0, 1, 3, 7, 16, 33};
        int seq0, npulse;
        rst_n = 0; enable = 1; clear_stb = 0; snapshot_stb = 0; window_cycles = 0;
        tuser = 0;
        drive(0, 0, 0, 8'h00);
        step(); step();
        chk("reset sat seq", sq1, 0);
        chk("reset wrap counts", c2, 0);
        rst_n = 1;

        // continuous 4-byte beats, 10-cycle window
        clear_stb = 1; window_cycles = 10; drive(1, 1, 0, 8'h0F); step();
        clear_stb = 0; beat_acc = 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (k > 10 && snap_valid) begin
                chk("win10 active", snap_counts[2], 10);
                chk("win10 bytes", snap_counts[0], 40);
            end
        end
        window_cycles = 0; drive(0, 0, 0, 8'h00); snapshot_stb = 1; step();
        chk("win10 beat sum", beat_acc, 100);

        // back-pressure runs, manual snapshots
        snapshot_stb = 0; clear_stb = 1; step(); clear_stb = 0;
        drive(1, 0, 0, 8'hFF); repeat (7) step();
        drive(1, 1, 0, 8'hFF); step();
        drive(1, 0, 0, 8'hFF); repeat (3) step();
        drive(0, 0, 0, 8'h00); snapshot_stb = 1; step();
        chk("bp count", snap_counts[4], 10);
        chk("bp max run", snap_counts[8], 7);
        chk("bp active", snap_counts[2], 1);
        step();
        chk("idle snap idle", snap_counts[1], 1);
        chk("idle snap max run", snap_counts[8], 0);
        snapshot_stb = 0;

        // frame whose tlast lands one cycle after a window trigger
        clear_stb = 1; window_cycles = 5; step(); clear_stb = 0;
        repeat (3) step();
        drive(1, 1, 0, 8'hFF); step();
        step();
        chk("span first valid", snap_valid, 1);
        chk("span first frame", snap_counts[5], 0);
        chk("span first maxlen", snap_counts[7], 0);
        drive(1, 1, 1, 8'h1F); step();
        drive(0, 0, 0, 8'h00); repeat (4) step();
        chk("span second frame", snap_counts[5], 1);
        chk("span second maxlen", snap_counts[7], 21);

        // snapshot_stb coinciding with window expiry
        clear_stb = 1; window_cycles = 4; step(); clear_stb = 0;
        drive(1, 1, 0, 8'h03); repeat (3) step();
        seq0 = snap_seq; snapshot_stb = 1; step(); snapshot_stb = 0;
        chk("coincide seq", snap_seq, seq0 + 1);
        npulse = 0;
        for (int k = 0; k < 4; k++) begin step(); npulse += snap_valid; end
        chk("coincide restart pulses", npulse, 1);

        // clear together with snapshot
        snapshot_stb = 1; clear_stb = 1; step(); snapshot_stb = 0; clear_stb = 0;
        chk("clear+stb valid", snap_valid, 0);
        chk("clear+stb counts", snap_counts[2], 0);

        // 4-bit counters: saturate vs wrap
        window_cycles = 0; drive(0, 0, 0, 8'h00); clear_stb = 1; step(); clear_stb = 0;
        drive(1, 1, 0, 8'h01); repeat (20) step();
        drive(0, 0, 0, 8'h00); snapshot_stb = 1; step(); snapshot_stb = 0;
        chk("sat active", c1[2], 15);
        chk("sat overflow", o1[2], 1);
        chk("wrap active", c2[2], 4);
        chk("wrap overflow", o2[2], 1);

        // error classification on 2-bit tuser
        clear_stb = 1; step(); clear_stb = 0;
        tuser = 2'b11;
        drive(1, 1, 0, 8'h01); repeat (2) step();
        drive(1, 1, 1, 8'h01); step();
        drive(0, 0, 0, 8'h00); tuser = 0; snapshot_stb = 1; step(); snapshot_stb = 0;
        chk("err every beat", c1[6], 3);
        chk("err tlast only", c2[6], 1);

        // randomized traffic, windows, strobes, clears and one reset
        for (int k = 0; k < 2000; k++) begin
            enable       = ($urandom_range(9) != 0);
            drive($urandom_range(1), $urandom_range(1), $urandom_range(3) == 0, 8'($urandom));
            tuser        = 2'($urandom);
            snapshot_stb = ($urandom_range(19) == 0);
            clear_stb    = ($urandom_range(199) == 0);
            rst_n        = (k != 1000);
            if ($urandom_range(99) == 0) window_cycles = 32'(wsel[$urandom_range(5)]);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
